// File: rtl/fpnew_result_buffer.sv
// Result FIFO that sits after an fpnew opgroup block. It buffers results, presents them
// to writeback in arrival order, and accumulates sticky IEEE flags over retired entries.
module fpnew_result_buffer #(
  parameter int unsigned Width    = 32,
  parameter int unsigned Depth    = 4,
  parameter type         TagType  = logic,
  parameter int unsigned CntWidth = $clog2(Depth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic [Width-1:0]    in_result_i,
  input  logic [4:0]          in_status_i,
  input  logic                in_ext_bit_i,
  input  TagType              in_tag_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  output logic [Width-1:0]    out_result_o,
  output logic [4:0]          out_status_o,
  output logic                out_ext_bit_o,
  output TagType              out_tag_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [4:0]          fflags_o,
  input  logic                fflags_clr_i,
  output logic [CntWidth-1:0] count_o,
  output logic                busy_o
);

  localparam int unsigned AddrWidth = (Depth > 1) ? $clog2(Depth) : 1;

  typedef struct packed {
    logic [Width-1:0] result;
    logic [4:0]       status;
    logic             ext_bit;
    TagType           tag;
  } entry_t;

  entry_t                mem [Depth];
  entry_t                head;
  logic [AddrWidth-1:0]  wr_ptr;
  logic [AddrWidth-1:0]  rd_ptr;
  logic [CntWidth-1:0]   count_q;
  logic [4:0]            fflags_q;
  logic                  push;
  logic                  pop;

  // Handshake flags come only from the registered count, so in_ready_o never
  // depends combinationally on out_ready_i.
  assign in_ready_o  = (count_q != CntWidth'(Depth));
  assign out_valid_o = (count_q != '0);
  assign busy_o      = out_valid_o;
  assign count_o     = count_q;
  assign fflags_o    = fflags_q;

  // A flush cycle swallows any handshake presented with it.
  assign push = in_valid_i & in_ready_o & ~flush_i;
  assign pop  = out_valid_o & out_ready_i & ~flush_i;

  assign head          = out_valid_o ? mem[rd_ptr] : '0;
  assign out_result_o  = head.result;
  assign out_status_o  = head.status;
  assign out_ext_bit_o = head.ext_bit;
  assign out_tag_o     = head.tag;

  // NOTE: storage is deliberately not reset; the count gates every read, so stale
  // contents are never visible and the array can map onto plain flops or RAM.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= '{result: in_result_i, status: in_status_i,
                       ext_bit: in_ext_bit_i, tag: in_tag_i};
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AddrWidth'(1);
      if (pop)  rd_ptr <= rd_ptr + AddrWidth'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CntWidth'(1);
        2'b01:   count_q <= count_q - CntWidth'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Clear takes effect before the flags of a same-cycle pop are merged in.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fflags_q <= '0;
    end else if (fflags_clr_i) begin
      fflags_q <= pop ? head.status : 5'b0;
    end else if (pop) begin
      fflags_q <= fflags_q | head.status;
    end
  end

endmodule

// File: tb/tb_fpnew_result_buffer.sv
// Bench for fpnew_result_buffer: directed scenarios plus random traffic, checked against
// a queue-based reference model by a negedge monitor.
module tb_fpnew_result_buffer;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  typedef logic [7:0] tag_t;
  typedef struct {
    logic [31:0] result;
    logic [4:0]  status;
    logic        ext_bit;
    tag_t        tag;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready, in_ext, out_valid, out_ready, out_ext;
  logic             clr, busy;
  logic [WIDTH-1:0] in_result, out_result;
  logic [4:0]       in_status, out_status, fflags;
  tag_t             in_tag, out_tag;
  logic [CW-1:0]    count;

  int   n_checks = 0;
  int   n_errors = 0;
  bit   check_en = 1'b0;
  int   max_cnt  = 0;
  exp_t exp_q[$];
  tag_t pop_log[$];
  logic [4:0] m_fflags = 5'b0;

  fpnew_result_buffer #(
    .Width(WIDTH), .Depth(DEPTH), .TagType(tag_t)
  ) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_result_i(in_result), .in_status_i(in_status), .in_ext_bit_i(in_ext),
    .in_tag_i(in_tag), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .out_result_o(out_result), .out_status_o(out_status), .out_ext_bit_o(out_ext),
    .out_tag_o(out_tag), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .fflags_o(fflags), .fflags_clr_i(clr), .count_o(count), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT state with the model, log pops, then advance the model by the
  // handshakes that the coming rising edge will see.
  always @(negedge clk) begin : monitor
    int   sz;
    bit   m_pop, m_push;
    exp_t e;
    if (check_en) begin
      sz = exp_q.size();
      check("count", 64'(count), 64'(sz));
      check("in_ready", 64'(in_ready), 64'(sz != DEPTH));
      check("out_valid", 64'(out_valid), 64'(sz != 0));
      check("busy", 64'(busy), 64'(sz != 0));
      check("fflags", 64'(fflags), 64'(m_fflags));
      if (sz != 0) e = exp_q[0];
      else e = '{result: 32'h0, status: 5'h0, ext_bit: 1'b0, tag: 8'h0};
      check("head_result", 64'(out_result), 64'(e.result));
      check("head_status", 64'(out_status), 64'(e.status));
      check("head_ext", 64'(out_ext), 64'(e.ext_bit));
      check("head_tag", 64'(out_tag), 64'(e.tag));
      if (int'(count) > max_cnt) max_cnt = int'(count);
      if (out_valid && out_ready && !flush && !rst) pop_log.push_back(out_tag);

      if (rst) begin
        exp_q.delete();
        m_fflags = 5'b0;
      end else begin
        m_pop  = (sz != 0) && out_ready && !flush;
        m_push = in_valid && (sz != DEPTH) && !flush;
        if (clr)        m_fflags = m_pop ? e.status : 5'b0;
        else if (m_pop) m_fflags = m_fflags | e.status;
        if (flush) exp_q.delete();
        if (m_pop) void'(exp_q.pop_front());
        if (m_push) begin
          e = '{result: in_result, status: in_status, ext_bit: in_ext, tag: in_tag};
          exp_q.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input tag_t t, input logic [31:0] r, input logic [4:0] s, input logic x);
    in_valid  = 1'b1;
    in_tag    = t;
    in_result = r;
    in_status = s;
    in_ext    = x;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_result = '0; in_status = '0; in_ext = 1'b0; in_tag = '0;

    // Reset then idle
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_en = 1'b1;
    tick();
    check("reset_idle_ready", 64'(in_ready), 64'(1));
    check("reset_idle_count", 64'(count), 64'(0));

    // Fill with backpressure: tag 5 must wait upstream
    pop_log.delete();
    for (int k = 1; k <= 5; k++) begin
      set_in(tag_t'(k), $urandom, 5'($urandom), 1'($urandom));
      tick();
    end
    check("full_in_ready", 64'(in_ready), 64'(0));
    check("full_count", 64'(count), 64'(DEPTH));
    out_ready = 1'b1;
    tick();
    check("ready_after_pop", 64'(in_ready), 64'(1));
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    check("fill_pops", 64'(pop_log.size()), 64'(5));
    for (int k = 0; k < pop_log.size(); k++) check("fill_order", 64'(pop_log[k]), 64'(k + 1));

    // Streaming at one entry per cycle
    pop_log.delete();
    max_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      set_in(tag_t'(i), $urandom, 5'($urandom), 1'($urandom));
      tick();
      if (i == 0) check("stream_first_valid", 64'(out_valid), 64'(1));
    end
    in_valid = 1'b0;
    repeat (3) tick();
    check("stream_pops", 64'(pop_log.size()), 64'(100));
    check("stream_max_count", 64'(max_cnt <= 1), 64'(1));
    for (int i = 0; i < pop_log.size(); i++) check("stream_order", 64'(pop_log[i]), 64'(i[7:0]));

    // Sticky flags
    out_ready = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    set_in(8'd21, $urandom, 5'b00001, 1'b0); tick();
    set_in(8'd22, $urandom, 5'b10000, 1'b0); tick();
    set_in(8'd23, $urandom, 5'b00100, 1'b0); tick();
    in_valid = 1'b0;
    check("flags_push_only", 64'(fflags), 64'(0));
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    check("flags_sticky", 64'(fflags), 64'(5'b10001));
    out_ready = 1'b1;
    clr = 1'b1;
    tick();
    out_ready = 1'b0;
    clr = 1'b0;
    check("flags_clr_pop", 64'(fflags), 64'(5'b00100));

    // Flush with simultaneous push and pop
    for (int k = 0; k < 3; k++) begin
      set_in(tag_t'(11 + k), $urandom, 5'b11111, 1'b1);
      tick();
    end
    in_valid = 1'b0;
    pop_log.delete();
    flush = 1'b1;
    out_ready = 1'b1;
    set_in(8'd9, 32'h9, 5'b01000, 1'b1);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_count", 64'(count), 64'(0));
    check("flush_valid", 64'(out_valid), 64'(0));
    check("flush_fflags", 64'(fflags), 64'(5'b00100));
    repeat (3) tick();
    check("flush_no_pops", 64'(pop_log.size()), 64'(0));
    out_ready = 1'b0;

    // Wrap-around: ten fill/drain rounds
    pop_log.delete();
    for (int i = 0; i < 10; i++) begin
      out_ready = 1'b0;
      for (int j = 0; j < 4; j++) begin
        set_in(tag_t'(4 * i + j), 32'h3F80_0000 + 32'(4 * i + j), 5'($urandom), 1'(j & 1));
        tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (4) tick();
    end
    tick();
    check("wrap_pops", 64'(pop_log.size()), 64'(40));
    for (int i = 0; i < pop_log.size(); i++) check("wrap_order", 64'(pop_log[i]), 64'(i));

    // Random traffic with occasional flush, clear and a mid-operation reset
    for (int c = 0; c < 400; c++) begin
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_tag    = tag_t'($urandom);
      in_result = $urandom;
      in_status = 5'($urandom);
      in_ext    = 1'($urandom);
      flush     = ($urandom_range(0, 31) == 0);
      clr       = ($urandom_range(0, 15) == 0);
      rst       = (c == 200) || (c == 201);
      tick();
    end
    rst = 1'b0; flush = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (DEPTH + 2) tick();
    check("final_empty", 64'(count), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
